// File: rtl/wb_timer_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_multi_if
// Brief    : Pipelined Wishbone slave bundle for the multi-channel timer.
// Revision : 1.0  initial release
// ============================================================================
interface wb_timer_multi_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [29:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_data
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface
`default_nettype wire

// File: rtl/wb_timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : wb_timer_multi
// Brief    : 64-bit prescaled tick counter with NCHAN compare channels
//            (one-shot / periodic reload), W1C status and maskable IRQ,
//            on a pipelined single-cycle-response Wishbone slave.
// Revision : 1.0  initial release
// ============================================================================
module wb_timer_multi #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int TICK_FREQ  = 1_000_000,
  parameter int NCHAN      = 4
) (
  input  wire               i_clk,
  input  wire               i_reset,
  wb_timer_multi_if.slave   wb,
  output logic              o_irq,
  output logic [NCHAN-1:0]  o_irq_vec
);

  localparam logic [31:0] c_PRESCALE_RST = 32'(CLOCK_FREQ / TICK_FREQ - 1);

  // Bus decode
  logic [5:0]       w_addr;
  logic             w_req, w_wr, w_rd;
  logic [31:0]      w_mask, w_wdata_m;
  logic             w_wr_lo, w_wr_hi, w_wr_pre, w_wr_stat, w_wr_ien, w_cnt_wr;
  logic             w_unused_addr;

  // Tick / match
  logic [31:0]      w_pre_new;
  logic             w_tick;
  logic [31:0]      w_cnt_lo_p1;
  logic [NCHAN-1:0] w_match, w_stat_clr;

  // Read path
  logic [31:0]      w_ch_rd [NCHAN];
  logic [31:0]      w_ch_rdata, w_rdata;

  // Global registers
  logic [63:0]      count_q, count_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      prescale_q, prescale_d;
  logic [31:0]      div_q, div_d;
  logic [NCHAN-1:0] status_q, status_d;
  logic [NCHAN-1:0] irq_en_q, irq_en_d;
  logic             ack_q;
  logic [31:0]      rdata_q;

  assign w_addr        = wb.i_wb_addr[5:0];
  assign w_unused_addr = ^wb.i_wb_addr[29:6];
  assign w_req         = wb.i_wb_cyc & wb.i_wb_stb & ~i_reset;
  assign w_wr          = w_req & wb.i_wb_we;
  assign w_rd          = w_req & ~wb.i_wb_we;
  assign w_mask        = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
                          {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
  assign w_wdata_m     = wb.i_wb_data & w_mask;

  assign w_wr_lo   = w_wr & (w_addr == 6'd0);
  assign w_wr_hi   = w_wr & (w_addr == 6'd1);
  assign w_wr_pre  = w_wr & (w_addr == 6'd2);
  assign w_wr_stat = w_wr & (w_addr == 6'd3);
  assign w_wr_ien  = w_wr & (w_addr == 6'd4);
  assign w_cnt_wr  = w_wr_lo | w_wr_hi;

  // Lowering PRESCALE beneath the running divider suppresses this cycle's tick
  assign w_pre_new   = (prescale_q & ~w_mask) | w_wdata_m;
  assign w_tick      = (div_q == prescale_q) & ~(w_wr_pre & (w_pre_new < div_q));
  assign w_cnt_lo_p1 = count_q[31:0] + 32'd1;
  assign w_stat_clr  = w_wr_stat ? w_wdata_m[NCHAN-1:0] : '0;

  // Per-channel compare / reload / control
  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    logic        w_hit, w_wr_cmp, w_wr_rel, w_wr_ctl;
    logic [31:0] cmp_q, cmp_d, reload_q, reload_d;
    logic        en_q, en_d, per_q, per_d;

    assign w_hit    = (w_addr[5:2] == 4'(k + 2));
    assign w_wr_cmp = w_wr & w_hit & (w_addr[1:0] == 2'd0);
    assign w_wr_rel = w_wr & w_hit & (w_addr[1:0] == 2'd1);
    assign w_wr_ctl = w_wr & w_hit & (w_addr[1:0] == 2'd2) & wb.i_wb_sel[0];

    // Matches never fire in a cycle whose COUNT is being overwritten
    assign w_match[k] = w_tick & ~w_cnt_wr & en_q & (w_cnt_lo_p1 == cmp_q);

    assign w_ch_rd[k] = !w_hit                ? 32'd0 :
                        (w_addr[1:0] == 2'd0) ? cmp_q :
                        (w_addr[1:0] == 2'd1) ? reload_q :
                        (w_addr[1:0] == 2'd2) ? {30'd0, per_q, en_q} : 32'd0;

    // Channel next state: bus writes take priority over match side-effects
    always_comb begin
      cmp_d    = cmp_q;
      reload_d = reload_q;
      en_d     = en_q;
      per_d    = per_q;
      if (w_wr_cmp)
        cmp_d = (cmp_q & ~w_mask) | w_wdata_m;
      else if (w_match[k] && per_q)
        cmp_d = cmp_q + reload_q;
      if (w_wr_rel)
        reload_d = (reload_q & ~w_mask) | w_wdata_m;
      if (w_wr_ctl) begin
        en_d  = wb.i_wb_data[0];
        per_d = wb.i_wb_data[1];
      end else if (w_match[k] && !per_q) begin
        en_d = 1'b0;
      end
    end

    // Channel register bank
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        cmp_q    <= '0;
        reload_q <= '0;
        en_q     <= 1'b0;
        per_q    <= 1'b0;
      end else begin
        cmp_q    <= cmp_d;
        reload_q <= reload_d;
        en_q     <= en_d;
        per_q    <= per_d;
      end
    end
  end

  // OR-combine channel read data; non-addressed channels contribute zero
  always_comb begin
    w_ch_rdata = '0;
    for (int k = 0; k < NCHAN; k++)
      w_ch_rdata = w_ch_rdata | w_ch_rd[k];
  end

  // Register read multiplexer
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      6'd0:    w_rdata = count_q[31:0];
      6'd1:    w_rdata = shadow_q;
      6'd2:    w_rdata = prescale_q;
      6'd3:    w_rdata = 32'(status_q);
      6'd4:    w_rdata = 32'(irq_en_q);
      default: w_rdata = w_ch_rdata;
    endcase
  end

  // Counter, prescaler, shadow, status and enable next state
  always_comb begin
    count_d    = count_q;
    shadow_d   = shadow_q;
    prescale_d = prescale_q;
    div_d      = div_q + 32'd1;
    irq_en_d   = irq_en_q;
    // Hardware set wins over a simultaneous W1C
    status_d   = (status_q & ~w_stat_clr) | w_match;

    if (w_cnt_wr || w_wr_pre || w_tick)
      div_d = '0;

    if (w_wr_lo)
      count_d[31:0] = (count_q[31:0] & ~w_mask) | w_wdata_m;
    if (w_wr_hi) begin
      count_d[63:32] = (count_q[63:32] & ~w_mask) | w_wdata_m;
      shadow_d       = (count_q[63:32] & ~w_mask) | w_wdata_m;
    end else if (w_rd && (w_addr == 6'd0)) begin
      shadow_d = count_q[63:32];
    end
    if (!w_cnt_wr && w_tick)
      count_d = count_q + 64'd1;

    if (w_wr_pre)
      prescale_d = w_pre_new;
    if (w_wr_ien)
      irq_en_d = (irq_en_q & ~w_mask[NCHAN-1:0]) | w_wdata_m[NCHAN-1:0];
  end

  // Global register bank and registered bus response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q    <= '0;
      shadow_q   <= '0;
      prescale_q <= c_PRESCALE_RST;
      div_q      <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      prescale_q <= prescale_d;
      div_q      <= div_d;
      status_q   <= status_d;
      irq_en_q   <= irq_en_d;
      ack_q      <= w_req;
      rdata_q    <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_data  = rdata_q;
  assign wb.o_wb_stall = i_reset;
  assign o_irq_vec     = status_q & irq_en_q;
  assign o_irq         = |(status_q & irq_en_q);

endmodule
`default_nettype wire

// File: doc/wb_timer_multi.md
Name: wb_timer_multi

Overview:
- Parametrised successor to the single free-running Wishbone timer.
- Provides a 64-bit tick counter with a runtime-programmable prescaler.
- Adds NCHAN compare channels, each one-shot or periodic auto-reload, with sticky write-1-to-clear status and a maskable interrupt output.
- Sits on the peripheral Wishbone bus (pipelined, single-cycle response) next to the other wb_iodevice blocks.

Parameters:
- CLOCK_FREQ, 50_000_000: i_clk frequency in Hz.
- TICK_FREQ, 1_000_000: default counter tick rate in Hz. PRESCALE resets to CLOCK_FREQ/TICK_FREQ-1.
- NCHAN, 4: number of compare channels, range 1..8.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  Wishbone cycle
- i_wb_stb  in  1  Wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  30  word address; only bits [5:0] are decoded
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  equals i_reset
- o_wb_data  out  32  read data
- o_irq  out  1  |(STATUS & IRQ_EN)
- o_irq_vec  out  NCHAN  STATUS & IRQ_EN

Behaviour:
- Register map (word address):
  - 0 COUNT_LO, RW
  - 1 COUNT_HI, RW
  - 2 PRESCALE, RW
  - 3 STATUS, W1C, bits [NCHAN-1:0]
  - 4 IRQ_EN, RW, bits [NCHAN-1:0]
  - 8+4k CMP_k, RW
  - 9+4k RELOAD_k, RW
  - 10+4k CTRL_k, RW: bit0 EN, bit1 PERIODIC
  - Unmapped addresses and channels k≥NCHAN: read 0, writes ignored.
- Reset values: all registers 0 except PRESCALE = CLOCK_FREQ/TICK_FREQ-1. Outputs: o_wb_ack=0, o_wb_data=0, o_irq=0.
- Bus handshake:
  - o_wb_ack is registered: high exactly one cycle after each accepted cyc&stb, one ack per request.
  - Back-to-back strobes are acked on consecutive cycles.
  - Dropping cyc forces ack low next cycle; in-flight requests are abandoned.
  - o_wb_data is registered with the ack.
- Byte lanes: i_wb_sel gates every write byte-wise, including STATUS W1C (only selected bytes clear).
- Coherent 64-bit read: reading COUNT_LO captures COUNT_HI into a shadow in the same cycle; reading COUNT_HI returns the shadow. A write to COUNT_HI also updates the shadow.
- Prescaler:
  - div counts 0..PRESCALE; tick=1 when div==PRESCALE, then div←0.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE to a value below the current div forces div←0 with no tick.
  - Any write to COUNT_LO/HI or PRESCALE resets div to 0.
- Counter: increments by 1 on tick, wrapping 2^64-1 → 0. On a tick coinciding with a COUNT write, the write wins and there is no increment that cycle.
- Match for channel k: tick & EN_k & (COUNT_LO+1 == CMP_k), 32-bit compare. Evaluated combinationally in the tick cycle; effects land on the same edge the counter advances:
  - STATUS_k←1.
  - If PERIODIC: CMP_k←CMP_k+RELOAD_k (mod 2^32), EN stays 1.
  - Else: EN_k←0.
- Simultaneous events:
  - A hardware set of STATUS_k in the same cycle as a W1C of bit k: set wins.
  - A match reload in the same cycle as a bus write to CMP_k: bus write wins.
  - A bus write to CTRL_k in the match cycle: bus value wins.
  - No match fires in a cycle where COUNT is written.
- Reset mid-transaction: no ack is issued for the pending request; all state returns to reset values next edge.

Test Plan:
- Reset, then read PRESCALE with defaults → 49. Wait 50×7 cycles, read COUNT_LO → 7 (±1 for bus latency).
- Write COUNT_LO=FFFF_FFFF, COUNT_HI=0, PRESCALE=0; after 1 tick read LO then HI → 0 and 1. Write HI=5, then read LO then HI → HI returns 5 with no torn value.
- PRESCALE=0, CMP_0=10, CTRL_0=1 (one-shot), IRQ_EN=1 → o_irq rises on the edge where COUNT_LO becomes 10. CTRL_0 then reads 0. Write STATUS=1 → o_irq low next cycle, no re-fire.
- PRESCALE=0, CMP_1=4, RELOAD_1=3, CTRL_1=3, IRQ_EN=2 → STATUS bit1 sets at counts 4, 7, 10. W1C issued in the exact cycle of the count-7 match leaves bit1 set.
- Write COUNT_LO with i_wb_sel=4'b0010, data 0x0000_AB00, over an old value of 0x1122_3344 → reads 0x1122_AB44. Read address 0x3F → 0 with ack. Issue 3 pipelined strobes → 3 acks on consecutive cycles.
- Assert i_reset during a strobe → no ack. All registers and o_irq read back at reset values.
